// File: rtl/program_loader.sv
// Boot-stage stream loader: takes a length header plus N words, writes them to memory
// from address 0, and holds the processor in reset until the image is in place.
module program_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int RST_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              LWE,
  output logic [ADDR_W-1:0] LADDR,
  output logic [DATA_W-1:0] LDATA,
  output logic              CPU_RST,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_HOLD, S_RUN, S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_in_ready;
  logic                r_lwe;
  logic [ADDR_W-1:0]   r_laddr;
  logic [DATA_W-1:0]   r_ldata;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_last;
  logic [7:0]          r_hold;
  logic                w_accept;
  logic                w_hdr_bad;
  logic                w_last_word;
  logic                w_hold_done;

  assign w_accept    = in_valid & r_in_ready;
  assign w_hdr_bad   = (in_data == '0) || (in_data > DATA_W'(DEPTH));
  assign w_last_word = (r_idx == r_last);
  assign w_hold_done = (r_hold == 8'(RST_HOLD - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (load_start) w_next = S_HDR;
      S_HDR:  if (w_accept) w_next = w_hdr_bad ? S_ERR : S_DATA;
      S_DATA: if (w_accept && w_last_word) w_next = S_HOLD;
      S_HOLD: if (w_hold_done) w_next = S_RUN;
      S_RUN:  if (load_start) w_next = S_HDR;
      S_ERR:  if (load_start) w_next = S_HDR;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_in_ready <= 1'b0;
      r_lwe      <= 1'b0;
      r_laddr    <= '0;
      r_ldata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_idx      <= '0;
      r_last     <= '0;
      r_hold     <= '0;
    end else begin
      r_in_ready <= (w_next == S_HDR) || (w_next == S_DATA);
      r_cpu_rst  <= (w_next != S_RUN);
      r_done     <= (w_next == S_RUN);
      r_error    <= (w_next == S_ERR);
      r_lwe      <= 1'b0;
      if (r_state == S_HDR && w_accept) begin
        r_last <= ADDR_W'(in_data - DATA_W'(1));
        r_idx  <= '0;
      end
      if (r_state == S_DATA && w_accept) begin
        r_lwe   <= 1'b1;
        r_laddr <= r_idx;
        r_ldata <= in_data;
        if (!w_last_word) r_idx <= r_idx + ADDR_W'(1);
      end
      if (r_state == S_HOLD) r_hold <= r_hold + 8'd1;
      else                   r_hold <= '0;
    end
  end

  assign in_ready = r_in_ready;
  assign LWE      = r_lwe;
  assign LADDR    = r_laddr;
  assign LDATA    = r_ldata;
  assign CPU_RST  = r_cpu_rst;
  assign done     = r_done;
  assign error    = r_error;

endmodule
